// File: rtl/unified_mem_arbiter.sv
// Arbiter sharing one single-port memory between the fetch port and the load/store port.
// The data port wins ties, and a per-access watchdog aborts accesses the memory never acknowledges.
module unified_mem_arbiter #(
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          if_req_i,
    input  logic [AW-1:0] if_addr_i,
    output logic [DW-1:0] if_rdata_o,
    output logic          if_ready_o,
    output logic          if_stall_o,
    input  logic          dm_req_i,
    input  logic          dm_we_i,
    input  logic [AW-1:0] dm_addr_i,
    input  logic [DW-1:0] dm_wdata_i,
    output logic [DW-1:0] dm_rdata_o,
    output logic          dm_ready_o,
    output logic          dm_stall_o,
    output logic          mem_req_o,
    output logic          mem_we_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [DW-1:0] mem_wdata_o,
    input  logic [DW-1:0] mem_rdata_i,
    input  logic          mem_ack_i,
    output logic          err_timeout_o
);

    localparam int unsigned CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_IF_BUSY = 2'd1;
    localparam logic [1:0] S_DM_BUSY = 2'd2;

    logic [1:0]    state_q,     state_d;
    logic [CW-1:0] cnt_q,       cnt_d;
    logic          mem_req_q,   mem_req_d;
    logic          mem_we_q,    mem_we_d;
    logic [AW-1:0] mem_addr_q,  mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic [DW-1:0] if_rdata_q,  if_rdata_d;
    logic [DW-1:0] dm_rdata_q,  dm_rdata_d;
    logic          if_ready_q,  if_ready_d;
    logic          dm_ready_q,  dm_ready_d;
    logic          err_q,       err_d;
    logic          done_c;

    // An access ends on ack, or on the last allowed BUSY cycle without one.
    assign done_c = mem_ack_i || (cnt_q == CNT_LAST);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;
        if_ready_d  = 1'b0;
        dm_ready_d  = 1'b0;
        err_d       = err_q;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                // A port whose ready is high has just completed and is not re-granted.
                if (dm_req_i && !dm_ready_q) begin
                    mem_req_d   = 1'b1;
                    mem_we_d    = dm_we_i;
                    mem_addr_d  = dm_addr_i;
                    mem_wdata_d = dm_wdata_i;
                    state_d     = S_DM_BUSY;
                end else if (if_req_i && !if_ready_q) begin
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = if_addr_i;
                    state_d    = S_IF_BUSY;
                end else begin
                    mem_req_d = 1'b0;
                end
            end
            S_IF_BUSY: begin
                if (done_c) begin
                    state_d    = S_IDLE;
                    mem_req_d  = 1'b0;
                    cnt_d      = '0;
                    if_ready_d = 1'b1;
                    if_rdata_d = mem_ack_i ? mem_rdata_i : '0;
                    if (!mem_ack_i) begin
                        err_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DM_BUSY: begin
                if (done_c) begin
                    state_d    = S_IDLE;
                    mem_req_d  = 1'b0;
                    cnt_d      = '0;
                    dm_ready_d = 1'b1;
                    if (!mem_ack_i) begin
                        dm_rdata_d = '0;
                        err_d      = 1'b1;
                    end else if (!mem_we_q) begin
                        dm_rdata_d = mem_rdata_i;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d   = S_IDLE;
                mem_req_d = 1'b0;
                cnt_d     = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
            if_ready_q  <= 1'b0;
            dm_ready_q  <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
            if_ready_q  <= if_ready_d;
            dm_ready_q  <= dm_ready_d;
            err_q       <= err_d;
        end
    end

    assign mem_req_o     = mem_req_q;
    assign mem_we_o      = mem_we_q;
    assign mem_addr_o    = mem_addr_q;
    assign mem_wdata_o   = mem_wdata_q;
    assign if_rdata_o    = if_rdata_q;
    assign dm_rdata_o    = dm_rdata_q;
    assign if_ready_o    = if_ready_q;
    assign dm_ready_o    = dm_ready_q;
    assign err_timeout_o = err_q;
    // Stall levels go straight to the pipeline hold logic.
    assign if_stall_o    = if_req_i & ~if_ready_q;
    assign dm_stall_o    = dm_req_i & ~dm_ready_q;

endmodule
